// File: rtl/dm_bus_arbiter_pkg.sv
// Shared constants and helpers for the two-requester debug-module bus arbiter.
package dm_bus_arbiter_pkg;

  // Number of upstream requesters (core data port and debug SBA).
  localparam int NumReq = 2;

  // Requester index constants; bit n of req_i/gnt_o/r_valid_o belongs to index n.
  localparam logic CoreIdx = 1'b0;
  localparam logic SbaIdx  = 1'b1;

  // Legal range and default for the number of in-flight transactions.
  localparam int MaxOutstandingMin     = 1;
  localparam int MaxOutstandingMax     = 4;
  localparam int MaxOutstandingDefault = 2;

  typedef logic req_idx_t;

  // Pick a requester from the raw request vector. A tie goes to the requester
  // that was not granted last, so the two alternate under sustained load.
  function automatic req_idx_t pick_requester(input logic [NumReq-1:0] req,
                                              input req_idx_t          last);
    req_idx_t pick;
    case (req)
      2'b01:   pick = CoreIdx;
      2'b10:   pick = SbaIdx;
      default: pick = ~last;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/dm_bus_arb_fifo.sv
// Owner FIFO: remembers which requester owns each in-flight downstream
// transaction so that in-order responses can be routed back.
module dm_bus_arb_fifo #(
  parameter int Depth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         data_i,
  input  logic                         pop_i,
  output logic                         data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when a pop frees a slot in the
  // same cycle; a pop from an empty FIFO is ignored.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer, storage and occupancy update; pointers wrap at Depth, which need
  // not be a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Two-requester arbiter (core data port, debug SBA) in front of a single
// in-order downstream bus with up to MaxOutstanding responses in flight.
//
// Handshake: a requester raises req_i[n] with its payload and holds both
// stable until gnt_o[n] is seen high at a clock edge; that edge is the
// transfer. Downstream follows the same rule with master_req_o/master_gnt_i.
// Responses carry no back-pressure: master_r_valid_i and r_valid_o are
// single-cycle strobes, and responses return in grant order.
module dm_bus_arbiter
  import dm_bus_arbiter_pkg::*;
#(
  parameter int BusWidth       = 32,
  parameter int MaxOutstanding = MaxOutstandingDefault  // legal 1..4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              req_i,
  input  logic [2*BusWidth-1:0]   add_i,
  input  logic [1:0]              we_i,
  input  logic [2*BusWidth-1:0]   wdata_i,
  input  logic [2*BusWidth/8-1:0] be_i,
  output logic [1:0]              gnt_o,
  output logic [1:0]              r_valid_o,
  output logic [BusWidth-1:0]     r_rdata_o,
  output logic                    r_err_o,
  output logic                    master_req_o,
  output logic [BusWidth-1:0]     master_add_o,
  output logic                    master_we_o,
  output logic [BusWidth-1:0]     master_wdata_o,
  output logic [BusWidth/8-1:0]   master_be_o,
  input  logic                    master_gnt_i,
  input  logic                    master_r_valid_i,
  input  logic [BusWidth-1:0]     master_r_rdata_i,
  input  logic                    master_r_err_i,
  output logic                    busy_o,
  output logic                    spurious_o
);

  localparam int BeW  = BusWidth / 8;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  req_idx_t        last_q;      // requester granted most recently
  logic            lock_q;      // a downstream request is pending without grant
  req_idx_t        lock_idx_q;  // requester that pending request belongs to
  req_idx_t        sel;
  logic            grant;
  logic            resp_ok;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_head;
  logic [CntW-1:0] fifo_count;

  // A pending downstream request keeps its requester; otherwise arbitrate.
  assign sel = lock_q ? lock_idx_q : pick_requester(req_i, last_q);

  // The full check uses registered occupancy only, so a pop in this cycle
  // does not reopen the request path until the next cycle.
  assign master_req_o   = rst_ni & ~fifo_full & req_i[sel];
  assign master_add_o   = sel ? add_i[2*BusWidth-1:BusWidth]   : add_i[BusWidth-1:0];
  assign master_we_o    = we_i[sel];
  assign master_wdata_o = sel ? wdata_i[2*BusWidth-1:BusWidth] : wdata_i[BusWidth-1:0];
  assign master_be_o    = sel ? be_i[2*BeW-1:BeW]              : be_i[BeW-1:0];

  // Grant is a pure combinational pass-through of the downstream grant.
  assign grant = master_req_o & master_gnt_i;
  assign gnt_o = sel ? {grant, 1'b0} : {1'b0, grant};

  // A response is routed to the FIFO head owner; with nothing outstanding it
  // is dropped and flagged instead.
  assign resp_ok    = rst_ni & master_r_valid_i & ~fifo_empty;
  assign r_valid_o  = fifo_head ? {resp_ok, 1'b0} : {1'b0, resp_ok};
  assign r_rdata_o  = master_r_rdata_i;
  assign r_err_o    = master_r_err_i;
  assign spurious_o = rst_ni & master_r_valid_i & fifo_empty;
  assign busy_o     = rst_ni & (fifo_count != '0);

  dm_bus_arb_fifo #(
    .Depth (MaxOutstanding)
  ) i_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .data_i  (sel),
    .pop_i   (resp_ok),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Arbitration history and selection lock; last_q resets to SbaIdx so the
  // core wins the first tie. The lock drops once the request is granted or
  // withdrawn.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q     <= SbaIdx;
      lock_q     <= 1'b0;
      lock_idx_q <= CoreIdx;
    end else begin
      if (grant) begin
        last_q <= sel;
      end
      lock_q <= master_req_o & ~master_gnt_i;
      if (master_req_o & ~master_gnt_i) begin
        lock_idx_q <= sel;
      end
    end
  end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed bench for dm_bus_arbiter with default parameters
// (BusWidth = 32, MaxOutstanding = 2).
module tb_dm_bus_arbiter;

  localparam int BusWidth = 32;
  localparam int BeW      = BusWidth / 8;
  localparam logic [BusWidth-1:0] A0 = 32'h0000_2000;
  localparam logic [BusWidth-1:0] A1 = 32'h0000_1000;
  localparam logic [BusWidth-1:0] W0 = 32'h1111_0000;
  localparam logic [BusWidth-1:0] W1 = 32'h2222_0000;

  // Clock and reset
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic [1:0]              req_i;
  logic [2*BusWidth-1:0]   add_i;
  logic [1:0]              we_i;
  logic [2*BusWidth-1:0]   wdata_i;
  logic [2*BeW-1:0]        be_i;
  logic [1:0]              gnt_o;
  logic [1:0]              r_valid_o;
  logic [BusWidth-1:0]     r_rdata_o;
  logic                    r_err_o;
  logic                    master_req_o;
  logic [BusWidth-1:0]     master_add_o;
  logic                    master_we_o;
  logic [BusWidth-1:0]     master_wdata_o;
  logic [BeW-1:0]          master_be_o;
  logic                    master_gnt_i;
  logic                    master_r_valid_i;
  logic [BusWidth-1:0]     master_r_rdata_i;
  logic                    master_r_err_i;
  logic                    busy_o;
  logic                    spurious_o;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected r_valid_o pattern for each outstanding transaction.
  logic [1:0] exp_q[$];

  dm_bus_arbiter #(
    .BusWidth       (BusWidth),
    .MaxOutstanding (2)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_i            (req_i),
    .add_i            (add_i),
    .we_i             (we_i),
    .wdata_i          (wdata_i),
    .be_i             (be_i),
    .gnt_o            (gnt_o),
    .r_valid_o        (r_valid_o),
    .r_rdata_o        (r_rdata_o),
    .r_err_o          (r_err_o),
    .master_req_o     (master_req_o),
    .master_add_o     (master_add_o),
    .master_we_o      (master_we_o),
    .master_wdata_o   (master_wdata_o),
    .master_be_o      (master_be_o),
    .master_gnt_i     (master_gnt_i),
    .master_r_valid_i (master_r_valid_i),
    .master_r_rdata_i (master_r_rdata_i),
    .master_r_err_i   (master_r_err_i),
    .busy_o           (busy_o),
    .spurious_o       (spurious_o)
  );

  // Driver tasks: inputs change 1 ns after posedge, outputs sampled at negedge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic idle();
    req_i            = 2'b00;
    add_i            = {A1, A0};
    we_i             = 2'b10;
    wdata_i          = {W1, W0};
    be_i             = {4'hC, 4'h3};
    master_gnt_i     = 1'b0;
    master_r_valid_i = 1'b0;
    master_r_rdata_i = '0;
    master_r_err_i   = 1'b0;
  endtask

  task automatic apply_reset();
    cyc();
    rst_ni = 1'b0;
    idle();
    cyc();
    cyc();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle();
    req_i = 2'b11; master_gnt_i = 1'b1; master_r_valid_i = 1'b1;
    cyc(); cyc(); smp();
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt_o); end
    checks++; if (r_valid_o !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", r_valid_o); end
    checks++; if (master_req_o !== 1'b0) begin errors++; $display("FAIL reset_mreq: got %b expected 0", master_req_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (spurious_o !== 1'b0) begin errors++; $display("FAIL reset_spurious: got %b expected 0", spurious_o); end
    cyc(); rst_ni = 1'b1; idle(); smp();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_sba_only();
    cyc(); req_i = 2'b10; master_gnt_i = 1'b1; smp();
    checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL sba_gnt: got %b expected 10", gnt_o); end
    checks++; if (master_req_o !== 1'b1) begin errors++; $display("FAIL sba_mreq: got %b expected 1", master_req_o); end
    checks++; if (master_add_o !== 32'h0000_1000) begin errors++; $display("FAIL sba_add: got %h expected 00001000", master_add_o); end
    checks++; if (master_we_o !== 1'b1) begin errors++; $display("FAIL sba_we: got %b expected 1", master_we_o); end
    cyc(); idle(); smp();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL sba_busy: got %b expected 1", busy_o); end
    checks++; if (r_valid_o !== 2'b00) begin errors++; $display("FAIL sba_early_rvalid: got %b expected 00", r_valid_o); end
    cyc(); master_r_valid_i = 1'b1; master_r_rdata_i = 32'hCAFE_F00D; master_r_err_i = 1'b1; smp();
    checks++; if (r_valid_o !== 2'b10) begin errors++; $display("FAIL sba_rvalid: got %b expected 10", r_valid_o); end
    checks++; if (r_rdata_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL sba_rdata: got %h expected cafef00d", r_rdata_o); end
    checks++; if (r_err_o !== 1'b1) begin errors++; $display("FAIL sba_rerr: got %b expected 1", r_err_o); end
    checks++; if (spurious_o !== 1'b0) begin errors++; $display("FAIL sba_spurious: got %b expected 0", spurious_o); end
    cyc(); idle(); smp();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL sba_idle_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt[4];
    logic [BusWidth-1:0] exp_add;
    logic [BusWidth-1:0] exp_wdata;
    logic [BeW-1:0] exp_be;
    logic exp_we;
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    apply_reset();
    idle();
    for (int i = 0; i < 5; i++) begin
      cyc();
      req_i            = (i < 4) ? 2'b11 : 2'b00;
      master_gnt_i     = (i < 4);
      master_r_valid_i = (i >= 1);
      master_r_rdata_i = 32'hA000_0000 + i;
      smp();
      if (i < 4) begin
        exp_add   = (i % 2 == 1) ? A1 : A0;
        exp_wdata = (i % 2 == 1) ? W1 : W0;
        exp_be    = (i % 2 == 1) ? 4'hC : 4'h3;
        exp_we    = (i % 2 == 1);
        checks++; if (gnt_o !== exp_gnt[i]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt_o, exp_gnt[i]); end
        checks++; if (master_add_o !== exp_add) begin errors++; $display("FAIL rr_add[%0d]: got %h expected %h", i, master_add_o, exp_add); end
        checks++; if (master_wdata_o !== exp_wdata) begin errors++; $display("FAIL rr_wdata[%0d]: got %h expected %h", i, master_wdata_o, exp_wdata); end
        checks++; if (master_be_o !== exp_be) begin errors++; $display("FAIL rr_be[%0d]: got %h expected %h", i, master_be_o, exp_be); end
        checks++; if (master_we_o !== exp_we) begin errors++; $display("FAIL rr_we[%0d]: got %b expected %b", i, master_we_o, exp_we); end
      end
      if (i >= 1) begin
        checks++; if (r_valid_o !== exp_gnt[i-1]) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, r_valid_o, exp_gnt[i-1]); end
      end
    end
    cyc(); idle(); smp();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rr_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_lock();
    apply_reset();
    idle();
    // One core transaction first so that a later tie would favour the SBA.
    cyc(); req_i = 2'b01; master_gnt_i = 1'b1; smp();
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL lock_warm_gnt: got %b expected 01", gnt_o); end
    cyc(); idle(); master_r_valid_i = 1'b1; smp();
    checks++; if (r_valid_o !== 2'b01) begin errors++; $display("FAIL lock_warm_rvalid: got %b expected 01", r_valid_o); end
    for (int c = 0; c < 3; c++) begin
      cyc(); idle(); req_i = (c == 0) ? 2'b01 : 2'b11; smp();
      checks++; if (master_req_o !== 1'b1) begin errors++; $display("FAIL lock_mreq[%0d]: got %b expected 1", c, master_req_o); end
      checks++; if (master_add_o !== A0) begin errors++; $display("FAIL lock_add[%0d]: got %h expected %h", c, master_add_o, A0); end
      checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL lock_gnt[%0d]: got %b expected 00", c, gnt_o); end
    end
    cyc(); req_i = 2'b11; master_gnt_i = 1'b1; smp();
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL lock_release_gnt: got %b expected 01", gnt_o); end
    checks++; if (master_add_o !== A0) begin errors++; $display("FAIL lock_release_add: got %h expected %h", master_add_o, A0); end
    cyc(); smp();
    checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL lock_next_gnt: got %b expected 10", gnt_o); end
    checks++; if (master_add_o !== A1) begin errors++; $display("FAIL lock_next_add: got %h expected %h", master_add_o, A1); end
    cyc(); idle(); master_r_valid_i = 1'b1; smp();
    checks++; if (r_valid_o !== 2'b01) begin errors++; $display("FAIL lock_drain0: got %b expected 01", r_valid_o); end
    cyc(); smp();
    checks++; if (r_valid_o !== 2'b10) begin errors++; $display("FAIL lock_drain1: got %b expected 10", r_valid_o); end
    cyc(); idle(); smp();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL lock_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_backpressure();
    logic [1:0] exp_rv;
    apply_reset();
    idle();
    exp_q.delete();
    for (int c = 0; c < 6; c++) begin
      cyc();
      idle();
      case (c)
        0: begin req_i = 2'b01; master_gnt_i = 1'b1; end
        1: begin req_i = 2'b10; master_gnt_i = 1'b1; end
        2: begin req_i = 2'b11; master_gnt_i = 1'b1; end
        3, 4: begin req_i = 2'b11; master_gnt_i = 1'b1; master_r_valid_i = 1'b1; end
        default: master_r_valid_i = 1'b1;
      endcase
      master_r_rdata_i = 32'hB000_0000 + c;
      smp();
      case (c)
        0: begin
          checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL bp_gnt0: got %b expected 01", gnt_o); end
          exp_q.push_back(2'b01);
        end
        1: begin
          checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL bp_gnt1: got %b expected 10", gnt_o); end
          exp_q.push_back(2'b10);
        end
        2, 3: begin
          checks++; if (master_req_o !== 1'b0) begin errors++; $display("FAIL bp_full_mreq[%0d]: got %b expected 0", c, master_req_o); end
          checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL bp_full_gnt[%0d]: got %b expected 00", c, gnt_o); end
          checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL bp_full_busy[%0d]: got %b expected 1", c, busy_o); end
        end
        4: begin
          checks++; if (master_req_o !== 1'b1) begin errors++; $display("FAIL bp_reopen_mreq: got %b expected 1", master_req_o); end
          checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL bp_reopen_gnt: got %b expected 01", gnt_o); end
        end
        default: ;
      endcase
      if (c >= 3) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_scoreboard[%0d]: got r_valid %b expected no response", c, r_valid_o);
        end else begin
          exp_rv = exp_q.pop_front();
          if (r_valid_o !== exp_rv) begin errors++; $display("FAIL bp_rvalid[%0d]: got %b expected %b", c, r_valid_o, exp_rv); end
        end
      end
      if (c == 4) exp_q.push_back(2'b01);
    end
    cyc(); idle(); smp();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL bp_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_spurious();
    cyc(); idle(); master_r_valid_i = 1'b1; master_r_rdata_i = 32'hDEAD_BEEF; smp();
    checks++; if (spurious_o !== 1'b1) begin errors++; $display("FAIL spur_pulse: got %b expected 1", spurious_o); end
    checks++; if (r_valid_o !== 2'b00) begin errors++; $display("FAIL spur_rvalid: got %b expected 00", r_valid_o); end
    cyc(); idle(); smp();
    checks++; if (spurious_o !== 1'b0) begin errors++; $display("FAIL spur_one_cycle: got %b expected 0", spurious_o); end
    // Grant and response in the same cycle: the response cannot belong to it.
    cyc(); req_i = 2'b01; master_gnt_i = 1'b1; master_r_valid_i = 1'b1; smp();
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL same_cyc_gnt: got %b expected 01", gnt_o); end
    checks++; if (spurious_o !== 1'b1) begin errors++; $display("FAIL same_cyc_spur: got %b expected 1", spurious_o); end
    checks++; if (r_valid_o !== 2'b00) begin errors++; $display("FAIL same_cyc_rvalid: got %b expected 00", r_valid_o); end
    cyc(); idle(); master_r_valid_i = 1'b1; smp();
    checks++; if (r_valid_o !== 2'b01) begin errors++; $display("FAIL next_cyc_rvalid: got %b expected 01", r_valid_o); end
    checks++; if (spurious_o !== 1'b0) begin errors++; $display("FAIL next_cyc_spur: got %b expected 0", spurious_o); end
    cyc(); idle(); smp();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL spur_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_mid_reset();
    cyc(); idle(); req_i = 2'b10; master_gnt_i = 1'b1; smp();
    checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL mr_gnt: got %b expected 10", gnt_o); end
    cyc(); idle(); smp();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mr_busy_before: got %b expected 1", busy_o); end
    cyc(); rst_ni = 1'b0; smp();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mr_busy_in_reset: got %b expected 0", busy_o); end
    cyc(); rst_ni = 1'b1; smp();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mr_busy_after: got %b expected 0", busy_o); end
    cyc(); master_r_valid_i = 1'b1; smp();
    checks++; if (spurious_o !== 1'b1) begin errors++; $display("FAIL mr_spur: got %b expected 1", spurious_o); end
    checks++; if (r_valid_o !== 2'b00) begin errors++; $display("FAIL mr_rvalid: got %b expected 00", r_valid_o); end
    cyc(); idle(); smp();
    checks++; if (spurious_o !== 1'b0) begin errors++; $display("FAIL mr_spur_end: got %b expected 0", spurious_o); end
  endtask

  initial begin
    test_reset();
    test_sba_only();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_spurious();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded 200000 ns, expected completion");
    $fatal(1);
  end

endmodule
